// File: rtl/mem_ctrl.sv
// mem_ctrl: memory access controller between the CPU datapath bus and a
// 256-word RAM behind a 9-bit address. Holds MAR/MDR and sequences one
// single-word read or write onto the RAM's level-sensitive strobes.
//
// Handshake: the control unit asserts req_rd or req_wr for one cycle while
// busy is low. The access is taken at that edge, busy rises, and done pulses
// for exactly one cycle when the access completes. Requests and register
// loads seen while busy are ignored.
//
// Ports:
//   clk, clr_n          clock (rising edge), async active-low reset
//   bus_in              datapath bus (source for MAR/MDR loads)
//   mar_in, mdr_in      load MAR / MDR from bus_in (IDLE only)
//   req_rd, req_wr      one-cycle access requests (IDLE only)
//   mar_q, mdr_q        current MAR / MDR
//   busy, done, err     status: access in progress, completion pulse, sticky error
//   ram_read, ram_write RAM strobes (never both high)
//   ram_addr, ram_data  RAM address and bidirectional data
//   state_dbg           current FSM state for observation
module mem_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 9,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              req_rd,
  input  logic              req_wr,
  output logic [ADDR_W-1:0] mar_q,
  output logic [DATA_W-1:0] mdr_q,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    RD    = 3'd2,
    WR    = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = MEM_DEPTH[ADDR_W:0];

  state_t state_q, state_d;
  logic   op_wr_q, op_wr_d;   // latched direction of the access in flight
  logic   err_set;
  logic   out_of_range;
  logic   drive_en;

  // Extra top bit so MEM_DEPTH == 2**ADDR_W would still compare correctly.
  assign out_of_range = ({1'b0, mar_q} >= DEPTH_L);

  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_rd && req_wr) begin
          err_set = 1'b1;
        end else if (req_rd || req_wr) begin
          if (out_of_range) begin
            err_set = 1'b1;
          end else begin
            state_d = SETUP;
            op_wr_d = req_wr;
          end
        end
      end
      SETUP:   state_d = op_wr_q ? WR : RD;
      RD:      state_d = DONE;
      WR:      state_d = HOLD;
      HOLD:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      op_wr_q <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      if (err_set) err <= 1'b1;
    end
  end

  // MAR/MDR load only in IDLE so address and data stay frozen for the
  // whole access; MDR also captures RAM data on the edge closing RD.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      mar_q <= '0;
      mdr_q <= '0;
    end else begin
      if (state_q == IDLE && mar_in) mar_q <= bus_in[ADDR_W-1:0];
      if (state_q == IDLE && mdr_in) mdr_q <= bus_in;
      else if (state_q == RD)        mdr_q <= ram_data;
    end
  end

  // All strobes and enables decode registered state only, so they cannot
  // glitch on input activity and drop immediately on asynchronous reset.
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign ram_read  = (state_q == RD);
  assign ram_write = (state_q == WR);
  assign drive_en  = op_wr_q && (state_q == SETUP || state_q == WR || state_q == HOLD);
  assign ram_addr  = mar_q;
  assign ram_data  = drive_en ? mdr_q : {DATA_W{1'bz}};
  assign state_dbg = state_q;

endmodule
